// File: rtl/tx_fifo_drain_ctrl.sv
// rtl/tx_fifo_drain_ctrl.sv - pops TX FIFO bytes and hands them to the UART shifter with gap, flush and byte count
module tx_fifo_drain_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             cnt_clr,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_r_data,
  output logic             fifo_r_en,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_GAP,
    S_FLUSH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           resume_state;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             sent;
  logic             handshake;
  logic             enter_idle;

  assign tx_valid   = (state == S_HOLD);
  assign busy       = (state != S_IDLE);
  assign handshake  = tx_valid & tx_ready;
  assign enter_idle = (state != S_IDLE) && (state_nxt == S_IDLE);

  // Where to go once a byte (and its gap) is finished: flush wins, then another fetch, else rest
  always_comb begin
    resume_state = S_IDLE;
    if (flush) begin
      resume_state = S_FLUSH;
    end else if (en && !fifo_empty) begin
      resume_state = S_FETCH;
    end
  end

  // Next-state, gap counter and pop strobe
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    fifo_r_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush) begin
          state_nxt = S_FLUSH;
        end else if (en && !fifo_empty) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_r_en = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (tx_ready) begin
          if (gap_cycles != '0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = gap_cycles;
          end else begin
            state_nxt = resume_state;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = resume_state;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      S_FLUSH: begin
        fifo_r_en = !fifo_empty;
        if (fifo_empty) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, data capture, sent flag, done pulse and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      tx_data  <= '0;
      sent     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      if (state == S_FETCH) begin
        tx_data <= fifo_r_data;
      end
      if (enter_idle) begin
        sent <= 1'b0;
      end else if (handshake) begin
        sent <= 1'b1;
      end
      done <= enter_idle && (sent || handshake);
      if (cnt_clr) begin
        byte_cnt <= '0;
      end else if (handshake) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

endmodule
